// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART frame serializer (start, LSB-first data, optional parity, stop), one bit per CLK.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;
    logic                  par_en_q;
    logic                  par_bit_q;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop_cnt;
`endif
    logic                  last_bit;
    assign last_bit = bit_cnt == CW'(DATA_WIDTH - 1);
    // Outputs are loaded with the value of the state being entered, so TX_OUT/Busy stay registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= !Data_Valid;
                    Busy   <= Data_Valid;
                    if (Data_Valid) begin
                        shift_reg <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= ^P_DATA ^ PAR_TYP;
                        state     <= START;
                    end
                end
                START: begin
                    state     <= DATA;
                    bit_cnt   <= '0;
                    TX_OUT    <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                end
                DATA: begin
                    if (last_bit) begin
                        state  <= par_en_q ? PARITY : STOP;
                        TX_OUT <= par_en_q ? par_bit_q : 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                        stop_cnt <= 1'b0;
`endif
                    end else begin
                        bit_cnt   <= bit_cnt + CW'(1);
                        TX_OUT    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                    stop_cnt <= 1'b0;
`endif
                end
                STOP: begin
                    TX_OUT <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                    stop_cnt <= 1'b1;
                    state    <= stop_cnt ? IDLE : STOP;
                    Busy     <= !stop_cnt;
`else
                    state    <= IDLE;
                    Busy     <= 1'b0;
`endif
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule
